bus_sequencer: RTL and testbench

- Control sequencer for the W-bit tri-state register bus (four registers A–D, an external input driver and an A+B adder driver).
- Accepts one micro-command at a time over a valid/ready handshake and generates every bus-driver enable, register load and adder enable the datapath needs.
- Guarantees at most one bus driver per cycle, with an idle bus cycle between transfers.
- Sits between the command source (test harness or a future instruction decoder) and the bus datapath's control inputs.

---
 rtl/bus_sequencer.sv | 155 +++++++++++++++
 tb/tb_bus_sequencer.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// bus_sequencer: control sequencer for the four-register tri-state bus.
// Accepts one micro-command per valid/ready handshake and produces the
// driver enables, register loads and adder enables for the datapath.
// Outputs are decoded from registered state and captured command fields only.
//
// state     | meaning
// ----------+----------------------------------------------------------
// RST       | just out of reset, nothing driven, not ready
// IDLE      | cmdReady=1, waiting for a command
// DRIVE     | LOAD/MOVE transfer: one driver plus ld[dst]
// ADDCALC   | adder captures A+B, bus undriven
// ADDDRIVE  | adder drives the sum, ld[dst]
// GAP       | bus idle, done pulse, completed-command count advances
module bus_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cmdValid,
    input  logic [1:0]       cmdOp,
    input  logic [1:0]       cmdSrc,
    input  logic [1:0]       cmdDst,
    output logic             cmdReady,
    output logic             enbIn,
    output logic             enbA,
    output logic             enbB,
    output logic             enbC,
    output logic             enbD,
    output logic             ldA,
    output logic             ldB,
    output logic             ldC,
    output logic             ldD,
    output logic             enbAdd,
    output logic             enbBusA,
    output logic             done,
    output logic [CNT_W-1:0] opCount
);

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_MOVE = 2'b01;
    localparam logic [1:0] OP_ADD  = 2'b10;

    typedef enum logic [2:0] {
        S_RST      = 3'd0,
        S_IDLE     = 3'd1,
        S_DRIVE    = 3'd2,
        S_ADDCALC  = 3'd3,
        S_ADDDRIVE = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    state_t     state;
    state_t     state_next;
    logic [1:0] op_q;
    logic [1:0] src_q;
    logic [1:0] dst_q;
    logic       accept;
    logic [3:0] drv_vec;
    logic [3:0] ld_vec;

    // A command is taken only while sitting in IDLE.
    assign accept = (state == S_IDLE) && cmdValid;

    // State register; reset parks the sequencer in RST.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_RST;
        end else begin
            state <= state_next;
        end
    end

    // Capture the command fields on the accept edge; they are frozen until the next accept.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            op_q  <= 2'b00;
            src_q <= 2'b00;
            dst_q <= 2'b00;
        end else if (accept) begin
            op_q  <= cmdOp;
            src_q <= cmdSrc;
            dst_q <= cmdDst;
        end
    end

    // Completed-command counter, advanced as GAP is left; wraps silently.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            opCount <= '0;
        end else if (state == S_GAP) begin
            opCount <= opCount + CNT_W'(1);
        end
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        case (state)
            S_RST:      state_next = S_IDLE;
            S_IDLE: begin
                if (cmdValid) begin
                    case (cmdOp)
                        OP_LOAD, OP_MOVE: state_next = S_DRIVE;
                        OP_ADD:           state_next = S_ADDCALC;
                        default:          state_next = S_GAP;
                    endcase
                end
            end
            S_DRIVE:    state_next = S_GAP;
            S_ADDCALC:  state_next = S_ADDDRIVE;
            S_ADDDRIVE: state_next = S_GAP;
            S_GAP:      state_next = S_IDLE;
            default:    state_next = S_RST;
        endcase
    end

    // Moore output decode; bit 0 of the one-hot vectors is register A.
    always_comb begin
        cmdReady = 1'b0;
        enbIn    = 1'b0;
        enbAdd   = 1'b0;
        enbBusA  = 1'b0;
        done     = 1'b0;
        drv_vec  = 4'b0000;
        ld_vec   = 4'b0000;
        case (state)
            S_IDLE: cmdReady = 1'b1;
            S_DRIVE: begin
                ld_vec = 4'b0001 << dst_q;
                if (op_q == OP_LOAD) begin
                    enbIn = 1'b1;
                end else begin
                    drv_vec = 4'b0001 << src_q;
                end
            end
            S_ADDCALC: enbAdd = 1'b1;
            S_ADDDRIVE: begin
                enbBusA = 1'b1;
                ld_vec  = 4'b0001 << dst_q;
            end
            S_GAP: done = 1'b1;
            default: ;
        endcase
    end

    assign enbA = drv_vec[0];
    assign enbB = drv_vec[1];
    assign enbC = drv_vec[2];
    assign enbD = drv_vec[3];
    assign ldA  = ld_vec[0];
    assign ldB  = ld_vec[1];
    assign ldC  = ld_vec[2];
    assign ldD  = ld_vec[3];

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: drives bus_sequencer with directed vectors, multi-cycle
// corner sequences and a random command stream, alongside a behavioural
// datapath and a command-level reference model.
module tb_bus_sequencer;

    logic        clock;
    logic        reset;
    logic        cmdValid;
    logic [1:0]  cmdOp;
    logic [1:0]  cmdSrc;
    logic [1:0]  cmdDst;
    logic [15:0] in_data;

    logic        cmdReady, enbIn, enbA, enbB, enbC, enbD;
    logic        ldA, ldB, ldC, ldD, enbAdd, enbBusA, done;
    logic [15:0] opCount;

    logic        r4_ready, r4_enbIn, r4_enbA, r4_enbB, r4_enbC, r4_enbD;
    logic        r4_ldA, r4_ldB, r4_ldC, r4_ldD, r4_enbAdd, r4_enbBusA, r4_done;
    logic [3:0]  opCount4;

    int total = 0;
    int bad   = 0;

    bus_sequencer #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdOp(cmdOp),
        .cmdSrc(cmdSrc), .cmdDst(cmdDst), .cmdReady(cmdReady), .enbIn(enbIn),
        .enbA(enbA), .enbB(enbB), .enbC(enbC), .enbD(enbD),
        .ldA(ldA), .ldB(ldB), .ldC(ldC), .ldD(ldD),
        .enbAdd(enbAdd), .enbBusA(enbBusA), .done(done), .opCount(opCount)
    );

    bus_sequencer #(.CNT_W(4)) dut4 (
        .clock(clock), .reset(reset), .cmdValid(cmdValid), .cmdOp(cmdOp),
        .cmdSrc(cmdSrc), .cmdDst(cmdDst), .cmdReady(r4_ready), .enbIn(r4_enbIn),
        .enbA(r4_enbA), .enbB(r4_enbB), .enbC(r4_enbC), .enbD(r4_enbD),
        .ldA(r4_ldA), .ldB(r4_ldB), .ldC(r4_ldC), .ldD(r4_ldD),
        .enbAdd(r4_enbAdd), .enbBusA(r4_enbBusA), .done(r4_done), .opCount(opCount4)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Behavioural datapath controlled by the sequencer (registers are not reset).
    logic [15:0] dp [4] = '{default: 16'h0};
    logic [15:0] sum_q = 16'h0;
    logic [15:0] bus;

    always_comb begin
        bus = 16'h0;
        if (enbIn)        bus = in_data;
        else if (enbA)    bus = dp[0];
        else if (enbB)    bus = dp[1];
        else if (enbC)    bus = dp[2];
        else if (enbD)    bus = dp[3];
        else if (enbBusA) bus = sum_q;
    end

    always @(posedge clock) begin
        if (enbAdd) sum_q <= dp[0] + dp[1];
        if (ldA) dp[0] <= bus;
        if (ldB) dp[1] <= bus;
        if (ldC) dp[2] <= bus;
        if (ldD) dp[3] <= bus;
    end

    // Packed view: {ready, enbIn, enbA..D, ldA..D, enbAdd, enbBusA, done}
    logic [12:0] ctl;
    assign ctl = {cmdReady, enbIn, enbA, enbB, enbC, enbD,
                  ldA, ldB, ldC, ldD, enbAdd, enbBusA, done};

    // Command-level reference model
    logic [15:0] mdl [4] = '{default: 16'h0};
    int cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [3:0] one_hot(input logic [1:0] r);
        logic [3:0] v;
        v = 4'b1000 >> r;
        return v;
    endfunction

    // Expected control word k cycles after the accept edge
    function automatic logic [12:0] exp_ctl(input logic [1:0] op, input logic [1:0] src,
                                            input logic [1:0] dst, input int k);
        logic [12:0] r;
        r = 13'h0;
        case (op)
            2'd0: if (k == 0) r = {2'b01, 4'b0000, one_hot(dst), 3'b000};
                  else if (k == 1) r = 13'h0001;
                  else if (k == 2) r = 13'h1000;
            2'd1: if (k == 0) r = {2'b00, one_hot(src), one_hot(dst), 3'b000};
                  else if (k == 1) r = 13'h0001;
                  else if (k == 2) r = 13'h1000;
            2'd2: if (k == 0) r = 13'h0004;
                  else if (k == 1) r = {6'b000000, one_hot(dst), 3'b010};
                  else if (k == 2) r = 13'h0001;
                  else if (k == 3) r = 13'h1000;
            default: if (k == 0) r = 13'h0001;
                  else if (k == 1) r = 13'h1000;
        endcase
        return r;
    endfunction

    function automatic int exp_len(input logic [1:0] op);
        return (op == 2'd2) ? 4 : (op == 2'd3) ? 2 : 3;
    endfunction

    // Issue one command from IDLE, follow it to the next ready cycle, then
    // update the model and compare datapath and counters.
    task automatic do_cmd(input logic [1:0] op, input logic [1:0] src, input logic [1:0] dst,
                          input logic [15:0] data, input bit hold, output int cycles);
        int k;
        chk("ready_before_cmd", cmdReady, 1);
        cmdValid = 1'b1;
        cmdOp    = op;
        cmdSrc   = src;
        cmdDst   = dst;
        in_data  = data;
        step();
        if (!hold) cmdValid = 1'b0;
        k = 0;
        forever begin
            chk("ctl_timing", ctl, exp_ctl(op, src, dst, k));
            if (cmdReady || k >= 8) break;
            if (hold) begin
                cmdOp  = 2'($urandom_range(0, 3));
                cmdSrc = 2'($urandom_range(0, 3));
                cmdDst = 2'($urandom_range(0, 3));
            end
            step();
            k++;
        end
        cycles = k + 1;
        chk("cmd_cycles", cycles, exp_len(op));
        case (op)
            2'd0: mdl[dst] = data;
            2'd1: mdl[dst] = mdl[src];
            2'd2: mdl[dst] = mdl[0] + mdl[1];
            default: ;
        endcase
        cnt++;
        for (int r = 0; r < 4; r++) chk("reg_value", dp[r], mdl[r]);
        chk("op_count", opCount, cnt[15:0]);
        chk("op_count4", opCount4, cnt[3:0]);
    endtask

    // Bus invariants on every cycle out of reset
    int  ndrv, nld;
    bit  prev_drv = 1'b0;
    always @(negedge clock) begin
        if (reset) begin
            ndrv = $countones({enbIn, enbA, enbB, enbC, enbD, enbBusA});
            nld  = $countones({ldA, ldB, ldC, ldD});
            chk("single_driver", ndrv <= 1, 1);
            chk("single_load", nld <= 1, 1);
            chk("bus_idle_gap", (ndrv != 0) && prev_drv, 0);
            prev_drv = (ndrv != 0);
        end else begin
            prev_drv = 1'b0;
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  src;
        logic [1:0]  dst;
        logic [15:0] data;
        logic [15:0] exp_val;
        int          exp_cycles;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int cyc;
        tbl[0]  = '{2'd0, 2'd0, 2'd1, 16'h1234, 16'h1234, 3};
        tbl[1]  = '{2'd0, 2'd0, 2'd0, 16'h0005, 16'h0005, 3};
        tbl[2]  = '{2'd0, 2'd0, 2'd1, 16'h0003, 16'h0003, 3};
        tbl[3]  = '{2'd1, 2'd0, 2'd2, 16'h0000, 16'h0005, 3};
        tbl[4]  = '{2'd2, 2'd0, 2'd3, 16'h0000, 16'h0008, 4};
        tbl[5]  = '{2'd1, 2'd2, 2'd2, 16'h0000, 16'h0005, 3};
        tbl[6]  = '{2'd1, 2'd3, 2'd1, 16'h0000, 16'h0008, 3};
        tbl[7]  = '{2'd2, 2'd0, 2'd0, 16'h0000, 16'h000D, 4};
        tbl[8]  = '{2'd3, 2'd0, 2'd0, 16'h0000, 16'h000D, 2};
        tbl[9]  = '{2'd0, 2'd0, 2'd3, 16'hFFFF, 16'hFFFF, 3};
        tbl[10] = '{2'd1, 2'd3, 2'd0, 16'h0000, 16'hFFFF, 3};
        tbl[11] = '{2'd2, 2'd0, 2'd2, 16'h0000, 16'h0007, 4};

        // Start-up: reset low for 3 cycles with a pending LOAD
        reset    = 1'b0;
        cmdValid = 1'b1;
        cmdOp    = 2'd0;
        cmdSrc   = 2'd0;
        cmdDst   = 2'd1;
        in_data  = 16'hBEEF;
        repeat (3) begin
            step();
            chk("reset_outputs", ctl, 0);
            chk("reset_count", opCount, 0);
        end
        reset = 1'b1;
        #1;
        chk("rst_state_not_ready", ctl, 0);
        step();
        chk("ready_after_release", ctl, 13'h1000);
        cmdValid = 1'b0;
        chk("no_accept_in_reset", dp[1], 16'h0000);

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            do_cmd(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].data, 1'b0, cyc);
            chk("tbl_dst_value", dp[tbl[i].dst], tbl[i].exp_val);
            chk("tbl_cycles", cyc, tbl[i].exp_cycles);
        end

        // Reset asserted during ADDDRIVE of ADD dst=D
        cmdValid = 1'b1;
        cmdOp    = 2'd2;
        cmdSrc   = 2'd0;
        cmdDst   = 2'd3;
        step();
        cmdValid = 1'b0;
        chk("midadd_calc", ctl, 13'h0004);
        step();
        chk("midadd_drive", ctl, {6'b0, 4'b0001, 3'b010});
        reset = 1'b0;
        #1;
        chk("midadd_async_drop", ctl, 0);
        chk("midadd_count_clear", opCount, 0);
        chk("midadd_count4_clear", opCount4, 0);
        step();
        chk("midadd_no_done", ctl, 0);
        chk("midadd_d_kept", dp[3], mdl[3]);
        step();
        reset = 1'b1;
        #1;
        chk("midadd_rst_state", ctl, 0);
        step();
        chk("midadd_ready", ctl, 13'h1000);
        cnt = 0;

        // Random back-to-back stream with cmdValid held high
        for (int i = 0; i < 20; i++) begin
            do_cmd(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   2'($urandom_range(0, 3)), 16'($urandom), 1'b1, cyc);
        end
        cmdValid = 1'b0;
        chk("stream_count", opCount, 20);

        // Counter wrap on the 4-bit instance with 17 NOPs
        reset = 1'b0;
        step();
        reset = 1'b1;
        step();
        cnt = 0;
        for (int i = 0; i < 17; i++) begin
            do_cmd(2'd3, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 16'h0, 1'b0, cyc);
            if (i == 14) chk("wrap_after_15", opCount4, 15);
            if (i == 15) chk("wrap_after_16", opCount4, 0);
            if (i == 16) chk("wrap_after_17", opCount4, 1);
        end

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
